alu_ex_stage: RTL and testbench

- Execute stage placed directly downstream of the ALU decoder in the CPU datapath.
- Consumes the 3-bit ALU control code together with two 32-bit operands and the destination-register tag.
- Computes the logic result and zero flag, then buffers the result toward the MEM stage.
- Buffering is a 2-entry skid buffer with valid/ready handshakes, plus pipeline flush.

---
 rtl/alu_ex_stage_pkg.sv | 28 ++
 rtl/alu_ex_stage_logic.sv | 30 +++
 rtl/alu_ex_stage.sv | 131 +++++++++++++
 tb/tb_alu_ex_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ex_stage_pkg.sv
// Shared ALU control codes, result bundle and occupancy encoding for the execute stage.
package alu_ex_stage_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_NOR = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b100;

  localparam int unsigned EX_WIDTH = 32;
  localparam int unsigned EX_REGW  = 5;

  // Result bundle at the default datapath widths.
  typedef struct packed {
    logic [EX_WIDTH-1:0] aluout;
    logic                zero;
    logic                illegal;
    logic [EX_REGW-1:0]  writereg;
    logic                regwrite;
  } ex_result_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_TWO
  } occ_e;

endpackage

// File: rtl/alu_ex_stage_logic.sv
// Combinational ALU core: result, zero flag and reserved-code detection.
module alu_logic
  import alu_ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  // Select the operation; reserved codes yield a zero result and flag illegal.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alucontrol)
      ALU_AND: result = srca & srcb;
      ALU_OR:  result = srca | srcb;
      ALU_NOR: result = ~(srca | srcb);
      ALU_XOR: result = srca ^ srcb;
      ALU_LUI: result = WIDTH'({srcb[15:0], 16'h0000});
      default: illegal = 1'b1;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: ALU result buffered toward MEM through a 2-entry skid buffer with flush.
module alu_ex_stage
  import alu_ex_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [REGW-1:0]  writereg,
  input  logic             regwrite,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             zero,
  output logic             illegal,
  output logic [REGW-1:0]  out_writereg,
  output logic             out_regwrite
);

  typedef struct packed {
    logic [WIDTH-1:0] aluout;
    logic             zero;
    logic             illegal;
    logic [REGW-1:0]  writereg;
    logic             regwrite;
  } bundle_t;

  logic [WIDTH-1:0] res;
  logic             res_zero;
  logic             res_illegal;
  bundle_t          in_bundle;

  occ_e    occ_q, occ_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    accept, retire;

  alu_logic #(.WIDTH(WIDTH)) u_alu_logic (
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .result     (res),
    .zero       (res_zero),
    .illegal    (res_illegal)
  );

  // Assemble the incoming bundle; illegal ops never write the register file.
  always_comb begin
    in_bundle = '{aluout:   res,
                  zero:     res_zero,
                  illegal:  res_illegal,
                  writereg: writereg,
                  regwrite: regwrite & ~res_illegal};
  end

  // Occupancy transitions and data movement between input, skid and main registers.
  always_comb begin
    accept = in_valid & in_ready_q;
    retire = out_valid_q & out_ready;
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            main_d = in_bundle;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && retire) begin
            main_d = in_bundle;
          end else if (accept) begin
            skid_d = in_bundle;
            occ_d  = OCC_TWO;
          end else if (retire) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (retire) begin
            main_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
    // Handshake flags are registered from the next occupancy so in_ready never sees out_ready combinationally.
    out_valid_d = (occ_d != OCC_EMPTY);
    in_ready_d  = (occ_d != OCC_TWO);
  end

  // State and data registers; reset clears everything including the visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= OCC_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign aluout       = main_q.aluout;
  assign zero         = main_q.zero;
  assign illegal      = main_q.illegal;
  assign out_writereg = main_q.writereg;
  assign out_regwrite = main_q.regwrite;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Randomised self-checking bench for alu_ex_stage against a queue-based reference model.
module tb_alu_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alucontrol;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic [4:0]  writereg;
  logic        regwrite;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluout;
  logic        zero;
  logic        illegal;
  logic [4:0]  out_writereg;
  logic        out_regwrite;

  int total = 0;
  int bad   = 0;

  // Model: ordered list of pending results, capacity two.
  logic [39:0] mq[$];

  alu_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alucontrol   (alucontrol),
    .srca         (srca),
    .srcb         (srcb),
    .writereg     (writereg),
    .regwrite     (regwrite),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .aluout       (aluout),
    .zero         (zero),
    .illegal      (illegal),
    .out_writereg (out_writereg),
    .out_regwrite (out_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // Expected bundle {aluout, zero, illegal, writereg, regwrite} from the operation rules.
  function automatic logic [39:0] ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                         input logic [4:0] wr, input logic rw);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (c)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = ~(a | b);
      3'd3: r = a ^ b;
      3'd4: r = b * 32'd65536;
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {r, (r == 32'd0), ill, wr, rw & ~ill};
  endfunction

  function automatic logic [41:0] obs_state();
    return {out_valid, in_ready,
            out_valid ? {aluout, zero, illegal, out_writereg, out_regwrite} : 40'd0};
  endfunction

  function automatic logic [41:0] exp_state();
    return {mq.size() > 0, mq.size() < 2, (mq.size() > 0) ? mq[0] : 40'd0};
  endfunction

  // Drive one cycle of inputs and advance the model by the transfer rules.
  task automatic step(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wr, input logic rw, input logic ordy, input logic fl);
    logic acc, ret;
    in_valid = v; alucontrol = c; srca = a; srcb = b; writereg = wr; regwrite = rw;
    out_ready = ordy; flush = fl;
    acc = v && (mq.size() < 2);
    ret = (mq.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (ret) void'(mq.pop_front());
    if (fl) mq.delete();
    else if (acc) mq.push_back(ref_op(c, a, b, wr, rw));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 3'd0, 32'd0, 32'd0, 5'd0, 1'b0, ordy, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; alucontrol = 3'd0; srca = '0; srcb = '0; writereg = '0; regwrite = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({out_valid, in_ready, aluout, zero, illegal, out_writereg, out_regwrite} !== 42'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b r=%b out=%h z=%b il=%b wr=%0d rw=%b, want all 0",
               out_valid, in_ready, aluout, zero, illegal, out_writereg, out_regwrite);
    end
    rst_n = 1'b1;
    mq.delete();
    idle(1'b1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
  endtask

  task automatic test_basic_ops();
    step(1'b1, 3'd1, 32'h0000F0F0, 32'h00000F0F, 5'd3, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || aluout !== 32'h0000FFFF || zero !== 1'b0) begin
      bad++;
      $display("FAIL or_op: got v=%b out=%h z=%b, want v=1 out=0000ffff z=0", out_valid, aluout, zero);
    end
    step(1'b1, 3'd4, 32'h5555AAAA, 32'h00001234, 5'd4, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || aluout !== 32'h12340000 || zero !== 1'b0) begin
      bad++;
      $display("FAIL lui_op: got v=%b out=%h z=%b, want v=1 out=12340000 z=0", out_valid, aluout, zero);
    end
    step(1'b1, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || aluout !== 32'h00000000 || zero !== 1'b1) begin
      bad++;
      $display("FAIL nor_zero: got v=%b out=%h z=%b, want v=1 out=00000000 z=1", out_valid, aluout, zero);
    end
    total++;
    if (obs_state() !== exp_state()) begin
      bad++;
      $display("FAIL nor_bundle: got %h want %h", obs_state(), exp_state());
    end
    idle(1'b1);
    total++;
    if (obs_state() !== exp_state()) begin
      bad++;
      $display("FAIL basic_drain: got %h want %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0, b0, a1, b1, a2, b2;
    a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    step(1'b1, 3'd0, a0, b0, 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd3, a1, b1, 5'd2, 1'b1, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || aluout !== (a0 & b0)) begin
      bad++;
      $display("FAIL bp_full: got r=%b v=%b out=%h, want r=0 v=1 out=%h", in_ready, out_valid, aluout, a0 & b0);
    end
    step(1'b1, 3'd1, a2, b2, 5'd3, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_state() !== exp_state() || aluout !== (a0 & b0)) begin
      bad++;
      $display("FAIL bp_hold: got %h want %h", obs_state(), exp_state());
    end
    step(1'b1, 3'd1, a2, b2, 5'd3, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || aluout !== (a1 ^ b1) || out_writereg !== 5'd2) begin
      bad++;
      $display("FAIL bp_second: got v=%b out=%h wr=%0d, want v=1 out=%h wr=2", out_valid, aluout, out_writereg, a1 ^ b1);
    end
    step(1'b1, 3'd1, a2, b2, 5'd3, 1'b1, 1'b1, 1'b0);
    total++;
    if (out_valid !== 1'b1 || aluout !== (a2 | b2) || out_writereg !== 5'd3) begin
      bad++;
      $display("FAIL bp_third: got v=%b out=%h wr=%0d, want v=1 out=%h wr=3", out_valid, aluout, out_writereg, a2 | b2);
    end
    idle(1'b1);
    total++;
    if (obs_state() !== exp_state()) begin
      bad++;
      $display("FAIL bp_drain: got %h want %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_throughput();
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      step(1'b1, 3'd3, a, b, 5'(i), 1'b1, 1'b1, 1'b0);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || aluout !== (a ^ b) || out_writereg !== 5'(i)) begin
        bad++;
        $display("FAIL throughput_%0d: got v=%b r=%b out=%h wr=%0d, want v=1 r=1 out=%h wr=%0d",
                 i, out_valid, in_ready, aluout, out_writereg, a ^ b, i);
      end
    end
    idle(1'b1);
    total++;
    if (obs_state() !== exp_state()) begin
      bad++;
      $display("FAIL throughput_drain: got %h want %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_reserved();
    step(1'b1, 3'b110, $urandom, $urandom, 5'd9, 1'b1, 1'b1, 1'b0);
    total++;
    if ({out_valid, aluout, zero, illegal, out_regwrite, out_writereg} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 5'd9}) begin
      bad++;
      $display("FAIL reserved: got v=%b out=%h z=%b il=%b rw=%b wr=%0d, want v=1 out=0 z=1 il=1 rw=0 wr=9",
               out_valid, aluout, zero, illegal, out_regwrite, out_writereg);
    end
    idle(1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, 3'd0, $urandom, $urandom, 5'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd1, $urandom, $urandom, 5'd2, 1'b1, 1'b0, 1'b0);
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup: got r=%b v=%b, want r=0 v=1", in_ready, out_valid);
    end
    step(1'b1, 3'd3, $urandom, $urandom, 5'd3, 1'b1, 1'b0, 1'b1);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_clear: got v=%b r=%b, want v=0 r=1", out_valid, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL flush_no_emerge_%0d: got v=%b out=%h, want v=0", i, out_valid, aluout);
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, 3'd3, $urandom, $urandom, 5'd4, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'd0, $urandom, $urandom, 5'd5, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || aluout !== 32'd0) begin
      bad++;
      $display("FAIL async_reset: got v=%b r=%b out=%h, want v=0 r=0 out=0", out_valid, in_ready, aluout);
    end
    mq.delete();
    #2;
    rst_n = 1'b1;
    idle(1'b1);
    total++;
    if (obs_state() !== exp_state()) begin
      bad++;
      $display("FAIL async_release: got %h want %h", obs_state(), exp_state());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
      total++;
      if (obs_state() !== exp_state()) begin
        bad++;
        $display("FAIL random_%0d: got %h want %h", i, obs_state(), exp_state());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_ops();
    test_backpressure();
    test_throughput();
    test_reserved();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
